// File: rtl/n101_jtag_master.sv
// JTAG shift master: shifts up to 32 TMS/TDI bits per command and returns captured TDO.
// Optional TRST output enabled by defining N101_JTAG_MASTER_TRST_EN.
module n101_jtag_master #(
  parameter int unsigned LEN_W = 5,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_tms,
  input  logic [31:0]      cmd_tdi,
`ifdef N101_JTAG_MASTER_TRST_EN
  input  logic             cmd_trst,
  output logic             jtag_trst_n,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_tdo,
  output logic             busy,
  output logic             jtag_tck,
  output logic             jtag_tms,
  output logic             jtag_tdi,
  input  logic             jtag_tdo
);

  localparam int unsigned IDX_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, div_q, div_n;
  logic [LEN_W-1:0] idx, idx_n, idx_inc, len_q, len_n;
  logic [31:0]      tms_vec, tms_vec_n, tdi_vec, tdi_vec_n, tdo_n;
  logic             tms_n, tdi_n;
`ifdef N101_JTAG_MASTER_TRST_EN
  logic             trst_n_n;
`endif

  // Next-state and next-output logic; every output is a register loaded from here.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_n     = div_q;
    idx_n     = idx;
    len_n     = len_q;
    tms_vec_n = tms_vec;
    tdi_vec_n = tdi_vec;
    tdo_n     = rsp_tdo;
    tms_n     = jtag_tms;
    tdi_n     = jtag_tdi;
`ifdef N101_JTAG_MASTER_TRST_EN
    trst_n_n  = jtag_trst_n;
`endif
    idx_inc   = idx + LEN_W'(1);
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n   = S_LOW;
          cnt_n     = '0;
          div_n     = cfg_div;
          idx_n     = '0;
          len_n     = cmd_len;
          tms_vec_n = cmd_tms;
          tdi_vec_n = cmd_tdi;
          tdo_n     = '0;
          tms_n     = cmd_tms[0];
          tdi_n     = cmd_tdi[0];
`ifdef N101_JTAG_MASTER_TRST_EN
          trst_n_n  = ~cmd_trst;
`endif
        end
      end
      S_LOW: begin
        if (cnt == div_q) begin
          cnt_n   = '0;
          state_n = S_HIGH;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (cnt == div_q) begin
          cnt_n                = '0;
          tdo_n[IDX_W'(idx)]   = jtag_tdo;
          if (idx == len_q) begin
            state_n = S_RESP;
`ifdef N101_JTAG_MASTER_TRST_EN
            trst_n_n = 1'b1;
`endif
          end else begin
            // Next bit launches together with the TCK falling edge.
            idx_n   = idx_inc;
            tms_n   = tms_vec[IDX_W'(idx_inc)];
            tdi_n   = tdi_vec[IDX_W'(idx_inc)];
            state_n = S_LOW;
          end
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      div_q       <= '0;
      idx         <= '0;
      len_q       <= '0;
      tms_vec     <= '0;
      tdi_vec     <= '0;
      rsp_tdo     <= '0;
      jtag_tck    <= 1'b0;
      jtag_tms    <= 1'b1;
      jtag_tdi    <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
`ifdef N101_JTAG_MASTER_TRST_EN
      jtag_trst_n <= 1'b1;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      div_q       <= div_n;
      idx         <= idx_n;
      len_q       <= len_n;
      tms_vec     <= tms_vec_n;
      tdi_vec     <= tdi_vec_n;
      rsp_tdo     <= tdo_n;
      jtag_tck    <= (state_n == S_HIGH);
      jtag_tms    <= tms_n;
      jtag_tdi    <= tdi_n;
      cmd_ready   <= (state_n == S_IDLE);
      rsp_valid   <= (state_n == S_RESP);
      busy        <= (state_n != S_IDLE);
`ifdef N101_JTAG_MASTER_TRST_EN
      jtag_trst_n <= trst_n_n;
`endif
    end
  end

endmodule

// File: tb/tb_n101_jtag_master.sv
// Bench for n101_jtag_master: directed and randomized commands against a cycle-index waveform model.
module tb_n101_jtag_master;
  localparam int unsigned LEN_W = 5;
  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0]      cmd_tms = '0;
  logic [31:0]      cmd_tdi = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_tdo;
  logic             busy;
  logic             jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
`ifdef N101_JTAG_MASTER_TRST_EN
  logic             cmd_trst = 1'b0;
  logic             jtag_trst_n;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int md = 0;
  int e_rst;

  always #5 clk = ~clk;

  // Target model: 0 loopback, 1 inverted loopback, 2 tied high, 3 tied low.
  always_comb begin
    case (md)
      0:       jtag_tdo = jtag_tdi;
      1:       jtag_tdo = ~jtag_tdi;
      2:       jtag_tdo = 1'b1;
      default: jtag_tdo = 1'b0;
    endcase
  end

  n101_jtag_master #(.LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
`ifdef N101_JTAG_MASTER_TRST_EN
    .cmd_trst(cmd_trst), .jtag_trst_n(jtag_trst_n),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo), .busy(busy),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete command: accept, shift checked per cycle, response hold, return to idle.
  task automatic run_cmd(input int len, input int d, input logic [31:0] tms, input logic [31:0] tdi,
                         input int mode, input int hold, input bit junk);
    logic [63:0] m64;
    logic [31:0] mask, exp_tdo;
    int k, last_k, p, b, e_shape, e_hs, e_stab;
    md = mode;
    m64 = (64'd1 << (len + 1)) - 64'd1;
    mask = m64[31:0];
    case (mode)
      0:       exp_tdo = tdi & mask;
      1:       exp_tdo = ~tdi & mask;
      2:       exp_tdo = mask;
      default: exp_tdo = 32'h0;
    endcase
    @(negedge clk);
    cfg_div = DIV_W'(d);
    cmd_len = LEN_W'(len);
    cmd_tms = tms;
    cmd_tdi = tdi;
    cmd_valid = 1'b1;
    chk("accept_rdy", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = junk;
    cmd_tms = $urandom;
    cmd_tdi = $urandom;
    cmd_len = LEN_W'($urandom);
    k = 1;
    last_k = 1 + (len + 1) * 2 * (d + 1);
    e_shape = 0;
    e_hs = 0;
    while (rsp_valid !== 1'b1 && k <= last_k + 4) begin
      p = k - 1;
      b = p / (2 * (d + 1));
      if (b > 31) e_shape++;
      else if (jtag_tck !== 1'((p / (d + 1)) % 2) || jtag_tms !== tms[b] || jtag_tdi !== tdi[b])
        e_shape++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) e_hs++;
      cfg_div = DIV_W'($urandom);
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    chk("rsp_time", 64'(k), 64'(last_k));
    chk("shift_wave", 64'(e_shape), 64'd0);
    chk("ready_busy", 64'(e_hs), 64'd0);
    chk("rsp_tdo", 64'(rsp_tdo), 64'(exp_tdo));
    chk("resp_flags", 64'({jtag_tck, cmd_ready, busy}), 64'(3'b001));
    e_stab = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_tdo !== exp_tdo || cmd_ready !== 1'b0) e_stab++;
    end
    chk("rsp_stable", 64'(e_stab), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("back_idle", 64'({rsp_valid, cmd_ready, busy, jtag_tck, jtag_tms, jtag_tdi}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, tms[len], tdi[len]}));
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_out", 64'({jtag_tck, jtag_tms, jtag_tdi, cmd_ready, rsp_valid, busy, rsp_tdo}),
        64'({6'b010000, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'({cmd_ready, busy}), 64'(2'b10));

    run_cmd(7, 1, 32'h0000_0000, 32'h0000_00A5, 0, 2, 1'b0);
    run_cmd(4, 0, 32'h0000_001F, 32'h0000_0000, 3, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("tms_idle_hold", 64'(jtag_tms), 64'd1);
    run_cmd(31, 0, 32'h1234_5678, 32'hDEAD_BEEF, 2, 1, 1'b1);
    run_cmd(5, 2, $urandom, $urandom, 1, 10, 1'b0);
    run_cmd(0, 0, 32'h0000_0001, 32'h0000_0001, 0, 0, 1'b1);

    // Reset during the HIGH phase of bit 2.
    @(negedge clk);
    cfg_div = DIV_W'(1);
    cmd_len = LEN_W'(7);
    cmd_tms = $urandom;
    cmd_tdi = $urandom;
    md = 0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_tck", 64'(jtag_tck), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 64'({jtag_tck, jtag_tms, jtag_tdi, busy, cmd_ready, rsp_valid, rsp_tdo}),
        64'({6'b010000, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    e_rst = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) e_rst++;
    end
    chk("no_rsp_after_abort", 64'(e_rst), 64'd0);
    run_cmd(7, 1, $urandom, 32'h0000_00A5, 0, 1, 1'b0);

    for (int n = 0; n < 16; n++) begin
      run_cmd(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/n101_jtag_master.md
N101_JTAG_MASTER -- requirements
Module: n101_jtag_master

Interface
REQ-001 SHALL have parameter LEN_W, default 5, bit-count field width; max command length 2^LEN_W = 32 bits.
REQ-002 SHALL have parameter DIV_W, default 8, clock-divider field width.
REQ-003 clk  input  1  sole clock; all state on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cfg_div  input  DIV_W  TCK half-period, in clk cycles, minus 1.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 cmd_len  input  LEN_W  number of bits to shift, minus 1.
REQ-009 cmd_tms  input  32  TMS vector, LSB first.
REQ-010 cmd_tdi  input  32  TDI vector, LSB first.
REQ-011 rsp_valid  output  1  captured TDO available.
REQ-012 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 rsp_tdo  output  32  captured TDO; bit i = bit i of the shift.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 jtag_tck  output  1  TCK to target.
REQ-016 jtag_tms  output  1  TMS to target.
REQ-017 jtag_tdi  output  1  TDI to target.
REQ-018 jtag_tdo  input  1  TDO from target; pre-synchronized by the pad wrapper.

Function
REQ-019 FSM states: IDLE, LOW, HIGH, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-020 Accept (IDLE, cmd_valid=1) SHALL latch cmd_len, cmd_tms, cmd_tdi and cfg_div, clear rsp_tdo, set bit index 0, drive tms/tdi from bit 0, and go to LOW.
REQ-021 LOW: jtag_tck=0 for exactly cfg_div+1 cycles, then HIGH.
REQ-022 HIGH: jtag_tck=1 for exactly cfg_div+1 cycles; in the last HIGH cycle, jtag_tdo SHALL be sampled into rsp_tdo[index].
REQ-023 HIGH end: if index = latched len, go to RESP with jtag_tck=0; otherwise increment index, drive tms/tdi from the next bit, and go to LOW.
REQ-024 tms/tdi SHALL change only on TCK falling edges or at accept, and SHALL hold their last value in RESP and IDLE.
REQ-025 rsp_valid SHALL be 1 only in RESP. rsp_tdo bits above len SHALL be 0.
REQ-026 RESP with rsp_ready=1 SHALL go to IDLE the next cycle; rsp_valid and rsp_tdo SHALL stay stable until then.
REQ-027 Timing: accept in cycle t0 gives rsp_valid first high in cycle t0+1+(len+1)*2*(cfg_div+1).
REQ-028 cfg_div changes during a command SHALL have no effect until the next accept.
REQ-029 cfg_div=0 SHALL give TCK = clk/2. cmd_len=0 SHALL shift exactly one bit.
REQ-030 cmd_valid in a state other than IDLE SHALL be ignored with no state change.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE with outputs: jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=0 while rst_n=0 then 1, rsp_valid=0, rsp_tdo=0, busy=0.
REQ-032 Reset mid-command SHALL abort the command with no response. The first accept after release SHALL behave per REQ-020.

Configuration
REQ-033 Macro N101_JTAG_MASTER_TRST_EN defined: SHALL add input cmd_trst (1) and output jtag_trst_n (1, reset 1). An accepted command with cmd_trst=1 SHALL drive jtag_trst_n=0 from the accept cycle+1 until entry to RESP, then 1.
REQ-034 Macro undefined: cmd_trst and jtag_trst_n SHALL be absent; all other behaviour identical.

Verification
REQ-035 cfg_div=1, cmd_len=7, tms=0x00, tdi=0xA5, target loops TDI to TDO -> 8 TCK pulses of 2 high/2 low cycles; rsp_tdo=0x000000A5; rsp_valid at t0+33.
REQ-036 cmd_len=4, tms=0x1F, cfg_div=0 -> TMS high on 5 rising edges; jtag_tms stays 1 in IDLE afterwards.
REQ-037 cmd_len=31, tdi=0xDEADBEEF, TDO tied 1 -> rsp_tdo=0xFFFFFFFF; cmd_ready=0 throughout; second cmd_valid mid-shift ignored.
REQ-038 rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_tdo stable; cmd_ready=0 until 1 cycle after rsp_ready.
REQ-039 rst_n pulsed low during 3rd bit HIGH phase -> tck=0, tms=1, busy=0 immediately; no rsp_valid; next command completes normally.
REQ-040 With N101_JTAG_MASTER_TRST_EN, cmd_trst=1, cmd_len=0 -> jtag_trst_n low for exactly 2*(cfg_div+1) cycles, then high.
